diff_sched: RTL and testbench

DIFF_SCHED -- requirements
Module: diff_sched

---
 rtl/diff_sched.sv | 120 ++++++++++++
 tb/tb_diff_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_sched.sv
// Shared-datapath ECG first-difference scheduler: round-robin arbitration over NCH
// channels, one sample per LOAD/CALC/OUT pass. Optional macro: DIFF_SCHED_PRIME_EN.
module diff_sched #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [NCH*8-1:0] d_in,
  output logic [NCH-1:0]   ack,
  output logic [8:0]       d_out,
  output logic [CW-1:0]    d_out_ch,
  output logic             d_out_valid,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_last_grant;
  logic [CW-1:0]    r_grant;
  logic [7:0]       r_sample;
  logic [7:0]       r_prev [NCH];
  logic [NCH-1:0]   r_ack;
  logic [8:0]       r_dout;
  logic [CW-1:0]    r_dout_ch;
  logic             r_valid;
`ifdef DIFF_SCHED_PRIME_EN
  logic [NCH-1:0]   r_primed;
`endif

  logic             w_any;
  logic [CW-1:0]    w_grant;
  logic [NCH-1:0]   w_onehot;
  logic [7:0]       w_sel;
  logic [8:0]       w_diff;

  // Round-robin search starting one past the last winner; first hit wins.
  always_comb begin
    w_any    = |req;
    w_grant  = r_last_grant;
    w_onehot = '0;
    for (int i = 1; i <= NCH; i++) begin
      int j;
      j = (int'(r_last_grant) + i) % NCH;
      if (req[j] && (w_onehot == '0)) begin
        w_grant     = CW'(j);
        w_onehot[j] = 1'b1;
      end
    end
  end

  assign w_sel  = d_in[int'(w_grant)*8 +: 8];
  // Mod-512 arithmetic yields the same low 9 bits as the 10-bit form; range is 1..511.
  assign w_diff = {1'b0, r_sample} + 9'd256 - {1'b0, r_prev[r_grant]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= CW'(NCH - 1);
      r_grant      <= '0;
      r_sample     <= '0;
      r_ack        <= '0;
      r_dout       <= 9'd256;
      r_dout_ch    <= '0;
      r_valid      <= 1'b0;
      for (int k = 0; k < NCH; k++) r_prev[k] <= '0;
`ifdef DIFF_SCHED_PRIME_EN
      r_primed     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_OUT: begin
          r_valid <= 1'b0;
          if (w_any) begin
            r_state      <= S_LOAD;
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_ack        <= w_onehot;
            r_sample     <= w_sel;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_ack   <= '0;
          r_state <= S_CALC;
        end
        S_CALC: begin
`ifdef DIFF_SCHED_PRIME_EN
          r_dout             <= r_primed[r_grant] ? w_diff : 9'd256;
          r_primed[r_grant]  <= 1'b1;
`else
          r_dout             <= w_diff;
`endif
          r_prev[r_grant] <= r_sample;
          r_dout_ch       <= r_grant;
          r_valid         <= 1'b1;
          r_state         <= S_OUT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack         = r_ack;
  assign d_out       = r_dout;
  assign d_out_ch    = r_dout_ch;
  assign d_out_valid = r_valid;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_diff_sched.sv
// Directed bench for diff_sched: latency, differencing, round-robin fairness,
// forfeited requests and reset abort. Honors DIFF_SCHED_PRIME_EN for first samples.
module tb_diff_sched;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   req;
  logic [NCH*8-1:0] d_in;
  logic [NCH-1:0]   ack;
  logic [8:0]       d_out;
  logic [CW-1:0]    d_out_ch;
  logic             d_out_valid;
  logic             busy;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  diff_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .d_in(d_in), .ack(ack),
    .d_out(d_out), .d_out_ch(d_out_ch), .d_out_valid(d_out_valid),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Expected output for a channel's first sample after reset.
  function automatic logic [8:0] first_out(input logic [7:0] data);
`ifdef DIFF_SCHED_PRIME_EN
    return 9'd256;
`else
    return {1'b0, data} + 9'd256;
`endif
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One request on channel ch; checks ack timing, output latency and value.
  task automatic send(input int ch, input logic [7:0] data, input logic [8:0] exp, input string name);
    int  n;
    bit  got;
    d_in[ch*8 +: 8] = data;
    req[ch] = 1'b1;
    got = 0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ack[ch]) got = 1;
    end
    total++;
    if (!got || n != 1) begin
      bad++;
      $display("FAIL %s ack_delay: got=%0d cycles (seen=%0d) want=1", name, n, got);
    end
    total++;
    if (ack !== (4'b0001 << ch)) begin
      bad++;
      $display("FAIL %s ack_onehot: got=%b want=%b", name, ack, 4'b0001 << ch);
    end
    req[ch] = 1'b0;
    got = 0;
    n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (d_out_valid) got = 1;
    end
    total++;
    if (!got || n != 2) begin
      bad++;
      $display("FAIL %s valid_delay: got=%0d cycles (seen=%0d) want=2", name, n, got);
    end
    total++;
    if (d_out !== exp) begin
      bad++;
      $display("FAIL %s d_out: got=%h want=%h", name, d_out, exp);
    end
    total++;
    if (d_out_ch !== CW'(ch)) begin
      bad++;
      $display("FAIL %s d_out_ch: got=%0d want=%0d", name, d_out_ch, ch);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (ack !== 4'b0000 || d_out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: got ack=%b valid=%b busy=%b want 0000/0/0", ack, d_out_valid, busy);
    end
    total++;
    if (d_out !== 9'h100 || d_out_ch !== 2'd0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_data: got d_out=%h ch=%0d st=%0d want 100/0/0", d_out, d_out_ch, dbg_state);
    end
  endtask

  task automatic test_latency();
    send(0, 8'h40, first_out(8'h40), "first_ch0");
    @(negedge clk);
    total++;
    if (d_out_valid !== 1'b0 || busy !== 1'b0 || d_out !== first_out(8'h40)) begin
      bad++;
      $display("FAIL hold_after_out: got valid=%b busy=%b d_out=%h want 0/0/%h",
               d_out_valid, busy, d_out, first_out(8'h40));
    end
  endtask

  task automatic test_sequence();
    send(0, 8'h30, 9'h0F0, "ch0_second");
  endtask

  task automatic test_extremes();
    send(1, 8'hFF, first_out(8'hFF), "ch1_first");
    send(1, 8'h00, 9'h001, "ch1_min");
    send(2, 8'h00, 9'h100, "ch2_first");
    send(2, 8'hFF, 9'h1FF, "ch2_max");
  endtask

  task automatic test_drop_while_busy();
    int  n;
    bit  stray;
    d_in[7:0] = 8'h35;
    req[0] = 1'b1;
    n = 0;
    while (!ack[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    req[0] = 1'b0;
    @(negedge clk);
    d_in[23:16] = 8'h77;
    req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    total++;
    if (d_out_valid !== 1'b1 || d_out !== 9'h105 || d_out_ch !== 2'd0) begin
      bad++;
      $display("FAIL busy_inflight: got valid=%b d_out=%h ch=%0d want 1/105/0", d_out_valid, d_out, d_out_ch);
    end
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[2] || d_out_valid) stray = 1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL forfeit_ch2: got stray ack/valid=1 want none");
    end
  endtask

  task automatic test_round_robin();
    int         exp_ch [5];
    logic [8:0] exp_val [5];
    int         n_ack, n_val, cyc, last_ack;
    apply_reset();
    exp_ch  = '{0, 1, 2, 3, 0};
    exp_val = '{first_out(8'h10), first_out(8'h20), first_out(8'h30), first_out(8'h40), 9'h108};
    d_in  = {8'h40, 8'h30, 8'h20, 8'h10};
    req   = 4'hF;
    n_ack = 0;
    n_val = 0;
    cyc   = 0;
    last_ack = 0;
    while (n_val < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack != '0 && n_ack < 5) begin
        total++;
        if (ack !== (4'b0001 << exp_ch[n_ack])) begin
          bad++;
          $display("FAIL rr_grant%0d: got ack=%b want ch%0d", n_ack, ack, exp_ch[n_ack]);
        end
        if (n_ack > 0) begin
          total++;
          if (cyc - last_ack != 3) begin
            bad++;
            $display("FAIL rr_spacing%0d: got %0d cycles want 3", n_ack, cyc - last_ack);
          end
        end
        last_ack = cyc;
        if (ack[0]) d_in[7:0] = 8'h18;
        n_ack++;
        if (n_ack == 5) req = '0;
      end
      if (d_out_valid) begin
        total++;
        if (d_out_ch !== CW'(exp_ch[n_val]) || d_out !== exp_val[n_val]) begin
          bad++;
          $display("FAIL rr_out%0d: got ch=%0d d_out=%h want ch=%0d d_out=%h",
                   n_val, d_out_ch, d_out, exp_ch[n_val], exp_val[n_val]);
        end
        n_val++;
      end
    end
    total++;
    if (n_val != 5) begin
      bad++;
      $display("FAIL rr_count: got %0d outputs want 5", n_val);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    bit stray;
    apply_reset();
    send(0, 8'h50, first_out(8'h50), "pre_abort");
    d_in[7:0] = 8'h60;
    req[0] = 1'b1;
    n = 0;
    while (!ack[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    req[0] = 1'b0;
    @(negedge clk);
    total++;
    if (dbg_state !== 2'd2) begin
      bad++;
      $display("FAIL abort_in_calc: got state=%0d want 2", dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (d_out_valid !== 1'b0 || d_out !== 9'h100 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got valid=%b d_out=%h busy=%b want 0/100/0", d_out_valid, d_out, busy);
    end
    rst = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_out_valid || ack != '0) stray = 1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL abort_quiet: got stray ack/valid=1 want none");
    end
    send(0, 8'h40, first_out(8'h40), "post_abort_ch0");
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    d_in = '0;
    test_reset();
    test_latency();
    test_sequence();
    test_extremes();
    test_drop_while_busy();
    test_round_robin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
